// File: rtl/logic_alu_pkg.sv
// Shared opcode and state encodings for the sequential logic ALU.
// Imported by the bitwise datapath and the sequencing top level.
package logic_alu_pkg;

    typedef enum logic [2:0] {
        OP_NOT  = 3'b000,
        OP_AND  = 3'b001,
        OP_OR   = 3'b010,
        OP_XOR  = 3'b011,
        OP_NAND = 3'b100,
        OP_NOR  = 3'b101,
        OP_ROL  = 3'b110,
        OP_ROR  = 3'b111
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        ROT  = 1'b1
    } state_e;

    function automatic logic is_rotate(op_e op);
        return (op == OP_ROL) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/logic_alu_seq_if.sv
// Request/response bundle of the sequential logic ALU.
// The requester uses the master view; the ALU uses the slave view.
interface logic_alu_seq_if #(
    parameter int WIDTH = 4
);

    logic             en;
    logic [2:0]       op;
    logic [WIDTH-1:0] Rd1;
    logic [WIDTH-1:0] Rd2;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (
        output en, op, Rd1, Rd2,
        input  result, zero, busy, done
    );

    modport slave (
        input  en, op, Rd1, Rd2,
        output result, zero, busy, done
    );

endinterface

// File: rtl/logic_alu_comb.sv
// Single-cycle bitwise datapath of the logic ALU.
// Rotate opcodes pass operand a through, which is the zero-amount rotate result.
module logic_alu_comb
    import logic_alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] y
);

    // NOTE: y gets a value on every path, including the default arm, so no latch is inferred.
    always_comb begin
        y = a;
        case (op)
            OP_NOT:  y = ~a;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            default: y = a;
        endcase
    end

endmodule

// File: rtl/logic_alu_seq.sv
// Sequential logic ALU: bitwise ops complete in one cycle, rotates take one
// cycle per bit position. result/zero only move together with the done pulse.
module logic_alu_seq
    import logic_alu_pkg::*;
#(
    parameter int WIDTH = 4  // power of two, at least 2
) (
    input logic            clk,
    input logic            rst,
    logic_alu_seq_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic             left_q, left_d;
    logic [WIDTH-1:0] alu_y;
    logic [WIDTH-1:0] rot_val;
    logic [WIDTH-1:0] load_val;
    logic             load;
    op_e              op;
    logic [CW-1:0]    amt;

    assign op  = op_e'(bus.op);
    assign amt = bus.Rd2[CW-1:0];

    logic_alu_comb #(
        .WIDTH(WIDTH)
    ) u_comb (
        .a (bus.Rd1),
        .b (bus.Rd2),
        .op(op),
        .y (alu_y)
    );

    assign rot_val = left_q ? {work_q[WIDTH-2:0], work_q[WIDTH-1]}
                            : {work_q[0], work_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        left_d   = left_q;
        load     = 1'b0;
        load_val = alu_y;
        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    if (is_rotate(op) && (amt != '0)) begin
                        work_d  = bus.Rd1;
                        cnt_d   = amt;
                        left_d  = (op == OP_ROL);
                        state_d = ROT;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            ROT: begin
                // Request inputs are deliberately not looked at here.
                work_d = rot_val;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    load     = 1'b1;
                    load_val = rot_val;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            work_q <= '0;
            left_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            work_q <= work_d;
            left_q <= left_d;
        end
    end

    // Reset also kills an in-flight rotate, so it can never reach done.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.result <= '0;
            bus.zero   <= 1'b0;
            bus.done   <= 1'b0;
        end else begin
            bus.done <= load;
            if (load) begin
                bus.result <= load_val;
                bus.zero   <= (load_val == '0);
            end
        end
    end

    assign bus.busy = (state_q == ROT);

endmodule

// File: tb/tb_logic_alu_seq.sv
// Directed bench for logic_alu_seq at WIDTH=4 with hand-computed expectations.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_logic_alu_seq;

    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic_alu_seq_if #(.WIDTH(WIDTH)) bus ();

    logic_alu_seq #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [2:0] op,
                         input logic [3:0] a, input logic [3:0] b);
        bus.en  = en;
        bus.op  = op;
        bus.Rd1 = a;
        bus.Rd2 = b;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] res, input logic z,
                             input logic dn, input logic bsy);
        check({tag, "_result"}, 8'(bus.result), 8'(res));
        check({tag, "_zero"},   8'(bus.zero),   8'(z));
        check({tag, "_done"},   8'(bus.done),   8'(dn));
        check({tag, "_busy"},   8'(bus.busy),   8'(bsy));
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 3'b000, 4'b1111, 4'b0000);
        tick();
        tick();
        check_out("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        drive(1'b0, 3'b000, 4'b0000, 4'b0000);
        tick();
        check_out("idle", 4'b0000, 1'b0, 1'b0, 1'b0);

        // NOT 1010 -> 0101, single-cycle
        drive(1'b1, 3'b000, 4'b1010, 4'b0000);
        tick();
        drive(1'b0, 3'b000, 4'b0000, 4'b0000);
        check_out("not", 4'b0101, 1'b0, 1'b1, 1'b0);
        tick();
        check_out("not_hold", 4'b0101, 1'b0, 1'b0, 1'b0);

        // Back-to-back XOR then AND
        drive(1'b1, 3'b011, 4'b1010, 4'b1010);
        tick();
        check_out("xor", 4'b0000, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 3'b001, 4'b1100, 4'b1010);
        tick();
        check_out("and", 4'b1000, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 3'b010, 4'b1100, 4'b0010);
        tick();
        check_out("or", 4'b1110, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 3'b100, 4'b1100, 4'b1010);
        tick();
        check_out("nand", 4'b0111, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 3'b101, 4'b1100, 4'b1010);
        tick();
        check_out("nor", 4'b0001, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 3'b010, 4'b0000, 4'b0000);
        tick();
        drive(1'b0, 3'b000, 4'b0000, 4'b0000);
        check_out("or_zero", 4'b0000, 1'b1, 1'b1, 1'b0);
        tick();
        check_out("or_zero_hold", 4'b0000, 1'b1, 1'b0, 1'b0);

        // ROL 0001 by 3, with ignored NOT requests during busy
        drive(1'b1, 3'b110, 4'b0001, 4'b0011);
        tick();
        check_out("rol3_n0", 4'b0000, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 3'b000, 4'b0000, 4'b0000);
        tick();
        check_out("rol3_n1", 4'b0000, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b0, 3'b000, 4'b0000, 4'b0000);
        check_out("rol3_n2", 4'b0000, 1'b1, 1'b0, 1'b1);
        tick();
        check_out("rol3_done", 4'b1000, 1'b0, 1'b1, 1'b0);
        tick();
        check_out("rol3_after", 4'b1000, 1'b0, 1'b0, 1'b0);

        // Preload a distinct result, then ROR by Rd2=5 (n=1)
        drive(1'b1, 3'b011, 4'b0110, 4'b0000);
        tick();
        check("xor_pre", 8'(bus.result), 8'h06);
        drive(1'b1, 3'b111, 4'b0001, 4'b0101);
        tick();
        drive(1'b0, 3'b000, 4'b0000, 4'b0000);
        check_out("ror1_n0", 4'b0110, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("ror1_done", 4'b1000, 1'b0, 1'b1, 1'b0);

        // ROL with Rd2=4 is a zero-amount rotate
        drive(1'b1, 3'b110, 4'b0101, 4'b0100);
        tick();
        drive(1'b0, 3'b000, 4'b0000, 4'b0000);
        check_out("rol0", 4'b0101, 1'b0, 1'b1, 1'b0);
        tick();
        check_out("rol0_after", 4'b0101, 1'b0, 1'b0, 1'b0);

        // ROR 0011 by 2 -> 1100, then NOT accepted in the done cycle
        drive(1'b1, 3'b111, 4'b0011, 4'b0010);
        tick();
        drive(1'b0, 3'b000, 4'b0000, 4'b0000);
        check_out("ror2_n0", 4'b0101, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("ror2_n1", 4'b0101, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("ror2_done", 4'b1100, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 3'b000, 4'b1111, 4'b0000);
        tick();
        drive(1'b0, 3'b000, 4'b0000, 4'b0000);
        check_out("b2b_not", 4'b0000, 1'b1, 1'b1, 1'b0);
        tick();
        check("b2b_done_low", 8'(bus.done), 8'h00);

        // ROL 0011 by 3 aborted by reset at edge N+2
        drive(1'b1, 3'b001, 4'b1111, 4'b0110);
        tick();
        check("and_pre", 8'(bus.result), 8'h06);
        drive(1'b1, 3'b110, 4'b0011, 4'b0011);
        tick();
        drive(1'b0, 3'b000, 4'b0000, 4'b0000);
        check_out("abort_n0", 4'b0110, 1'b0, 1'b0, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_out("abort_rst", 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        check_out("abort_no_done", 4'b0000, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3'b000, 4'b0000, 4'b0000);
        tick();
        drive(1'b0, 3'b000, 4'b0000, 4'b0000);
        check_out("post_abort_not", 4'b1111, 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
